// File: rtl/hex_display_pkg.sv
// Shared types and seven-segment constants for the BCD display controller.
// Optional feature macro used by the top: HEX_LEADING_ZERO_BLANK_EN.
package hex_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Active-low patterns, bit 7 = dp held off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to an active-low seven-segment pattern, with a forced-blank input.
// Non-decimal codes (10-15) render as blank.
module seg7_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) seg_o = seg_encode(bcd_i);
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD (double-dabble) converter driving six seven-segment displays.
// Define HEX_LEADING_ZERO_BLANK_EN to blank leading zero digits above HEX0.
module bcd_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [7:0]       HEX0,
  output logic [7:0]       HEX1,
  output logic [7:0]       HEX2,
  output logic [7:0]       HEX3,
  output logic [7:0]       HEX4,
  output logic [7:0]       HEX5,
  output state_t           state_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until the LATCH edge; done pulses for the one cycle after LATCH,
  // when busy is already low, so a start during done is accepted next edge.

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_adj;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bcd_q    <= '0;
      count_q  <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = value;
          bcd_d   = '0;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj[BW-2:0], shreg_q, 1'b0};
        count_d          = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        digits_d = bcd_q;
        valid_d  = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign state_o = state_q;

  // Nothing is shown until the first conversion has landed in the digit registers.
  logic [DIGITS-1:0] blank;
`ifdef HEX_LEADING_ZERO_BLANK_EN
  logic lead_zero;
  always_comb begin
    blank     = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (digits_q[4*i +: 4] == 4'd0);
      blank[i]  = !valid_q || (lead_zero && (i != 0));
    end
  end
`else
  always_comb begin
    blank = '0;
    for (int i = 0; i < DIGITS; i++) blank[i] = !valid_q;
  end
`endif

  logic [7:0] hex_w [6];

  for (genvar g = 0; g < 6; g++) begin : g_digit
    if (g < DIGITS) begin : g_dec
      seg7_decoder u_dec (
        .bcd_i   (digits_q[4*g +: 4]),
        .blank_i (blank[g]),
        .seg_o   (hex_w[g])
      );
    end else begin : g_off
      assign hex_w[g] = SEG_BLANK;
    end
  end

  assign HEX0 = hex_w[0];
  assign HEX1 = hex_w[1];
  assign HEX2 = hex_w[2];
  assign HEX3 = hex_w[3];
  assign HEX4 = hex_w[4];
  assign HEX5 = hex_w[5];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: expected HEX words are queued at each start
// and popped when done pulses.
module tb_bcd_display_ctrl;
  import hex_display_pkg::*;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;
  localparam int LAT    = WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             busy, done;
  logic [7:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  state_t           state_dbg;

  always #5 clk = ~clk;

  bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .state_o  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [47:0] model(input int v);
    logic [47:0] r;
    int p;
    bit blk;
    r = '1;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      blk = 1'b0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) blk = 1'b1;
`endif
      if (!blk) r[8*i +: 8] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [47:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [47:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=done expected=no_pending_result", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, hex_all(), e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input int v);
    value = WIDTH'(v);
    start = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input string tag, input int n0);
    int n, busyc, overlap;
    n = n0;
    busyc = busy ? n0 + 1 : 0;
    overlap = 0;
    while (!done && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busyc++;
      if (busy && done) overlap++;
    end
    check({tag, "_latency"}, 48'(n), 48'(LAT));
    check({tag, "_busy_in_done"}, 48'(busy), 48'd0);
    check({tag, "_overlap"}, 48'(overlap), 48'd0);
    if (n0 == 0) check({tag, "_busy_cycles"}, 48'(busyc), 48'(LAT));
    pop_check({tag, "_hex"});
  endtask

  task automatic quiet_cycles(input string tag, input int cycles);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check({tag, "_no_done"}, 48'(dones), 48'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    check("reset_hex", hex_all(), {48{1'b1}});
    check("reset_busy", 48'(busy), 48'd0);
    check("reset_done", 48'(done), 48'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    quiet_cycles("post_reset", 5);
    check("post_reset_hex", hex_all(), {48{1'b1}});
    check("post_reset_busy", 48'(busy), 48'd0);

    launch(0);
    wait_done("val0", 0);
    launch(1023);
    wait_done("val1023", 0);

    // start while busy is ignored and value changes do not disturb the capture
    launch(9);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    value = WIDTH'(500);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_start", 5);
    quiet_cycles("ignore_start", 15);
    launch(500);
    wait_done("val500", 0);

    // back-to-back: start raised during the done cycle
    launch(123);
    wait_done("b2b_first", 0);
    launch(456);
    wait_done("b2b_second", 0);

    // reset mid-conversion aborts and blanks
    launch(999);
    void'(exp_q.pop_back());
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    check("abort_busy", 48'(busy), 48'd0);
    check("abort_done", 48'(done), 48'd0);
    check("abort_hex", hex_all(), {48{1'b1}});
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    quiet_cycles("abort", 15);
    check("abort_hex_after", hex_all(), {48{1'b1}});
    launch(999);
    wait_done("val999", 0);

    for (int v = 0; v < 16; v++) begin
      launch(v);
      wait_done($sformatf("sweep%0d", v), 0);
    end

    for (int k = 0; k < 6; k++) begin
      launch(int'($urandom_range(0, 1023)));
      wait_done($sformatf("rand%0d", k), 0);
    end

    check("queue_empty", 48'(exp_q.size()), 48'd0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
